// File: rtl/fse_ctrl.sv
// fse_ctrl: sequencing controller for the fractionally spaced equalizer.
// Generates the shift/symbol strobes, owns the I/Q tap bank and applies LMS deltas.
`timescale 1ns/1ps
module fse_ctrl #(
  parameter int NUM_TAPS    = 9,
  parameter int NBT_TAPS    = 10,
  parameter int NBF_TAPS    = 7,
  parameter int ACQ_SYMBOLS = 1024,
  parameter int ACQ_SHIFT   = 2,
  parameter int TRK_SHIFT   = 5
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_en_rx,
  input  logic                         i_valid,
  input  logic                         i_freeze,
  input  logic                         i_upd_valid,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_upd_dI,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_upd_dQ,
  output logic                         o_upd_ready,
  output logic                         o_ctrl,
  output logic                         o_sym_strobe,
  output logic                         o_en_taps,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
  output logic [1:0]                   o_state
);

  localparam int TW     = NUM_TAPS * NBT_TAPS;
  localparam int FILL_W = $clog2(NUM_TAPS + 1);
  localparam int ACQ_W  = $clog2(ACQ_SYMBOLS + 1);
  // Center-spike initial I taps: 1.0 on the middle tap, zero elsewhere.
  localparam logic [TW-1:0] TAPS_I_INIT = TW'(1 << NBF_TAPS) << ((NUM_TAPS / 2) * NBT_TAPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ACQ   = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              phase;
  logic              pending;
  logic              run;
  logic              adapting;
  logic              take_sample;
  logic              sym_now;
  logic              xfer;
  logic [FILL_W-1:0] fill_cnt, fill_cnt_nxt;
  logic [ACQ_W-1:0]  acq_cnt, acq_cnt_nxt;
  logic [TW-1:0]     taps_I_nxt, taps_Q_nxt;

  // One extra bit of headroom catches overflow before clamping to the tap range.
  function automatic logic [NBT_TAPS-1:0] sat_add(input logic [NBT_TAPS-1:0] tap,
                                                  input logic [NBT_TAPS-1:0] delta,
                                                  input logic              trk);
    logic signed [NBT_TAPS-1:0] sh;
    logic [NBT_TAPS:0]          sum;
    sh  = trk ? ($signed(delta) >>> TRK_SHIFT) : ($signed(delta) >>> ACQ_SHIFT);
    sum = {tap[NBT_TAPS-1], tap} + {sh[NBT_TAPS-1], sh};
    if (sum[NBT_TAPS] != sum[NBT_TAPS-1])
      sat_add = sum[NBT_TAPS] ? {1'b1, {(NBT_TAPS-1){1'b0}}} : {1'b0, {(NBT_TAPS-1){1'b1}}};
    else
      sat_add = sum[NBT_TAPS-1:0];
  endfunction

  assign run         = i_reset & i_en_rx;
  assign adapting    = (state == ACQ) || (state == TRACK);
  assign take_sample = run & (state != IDLE) & i_valid;
  assign sym_now     = take_sample & phase;
  assign o_upd_ready = run & adapting & ~pending & ~i_freeze;
  assign xfer        = o_upd_ready & i_upd_valid;
  assign o_state     = state;

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    acq_cnt_nxt  = acq_cnt;
    unique case (state)
      IDLE:  state_nxt = FILL;
      FILL: begin
        if (take_sample) begin
          if (fill_cnt == FILL_W'(NUM_TAPS - 1)) state_nxt = ACQ;
          else fill_cnt_nxt = fill_cnt + FILL_W'(1);
        end
      end
      ACQ: begin
        if (sym_now) begin
          if (acq_cnt == ACQ_W'(ACQ_SYMBOLS - 1)) state_nxt = TRACK;
          else acq_cnt_nxt = acq_cnt + ACQ_W'(1);
        end
      end
      TRACK: state_nxt = TRACK;
    endcase
  end

  // Step size follows the state in the accept cycle, not the one after.
  always_comb begin
    taps_I_nxt = o_taps_I;
    taps_Q_nxt = o_taps_Q;
    for (int j = 0; j < NUM_TAPS; j++) begin
      taps_I_nxt[j*NBT_TAPS +: NBT_TAPS] = sat_add(o_taps_I[j*NBT_TAPS +: NBT_TAPS],
                                                   i_upd_dI[j*NBT_TAPS +: NBT_TAPS],
                                                   state == TRACK);
      taps_Q_nxt[j*NBT_TAPS +: NBT_TAPS] = sat_add(o_taps_Q[j*NBT_TAPS +: NBT_TAPS],
                                                   i_upd_dQ[j*NBT_TAPS +: NBT_TAPS],
                                                   state == TRACK);
    end
  end

  // Dropping the receiver enable behaves exactly like reset, discarding any pending update.
  always_ff @(posedge clk) begin
    if (!i_reset || !i_en_rx) begin
      state        <= IDLE;
      phase        <= 1'b0;
      pending      <= 1'b0;
      fill_cnt     <= '0;
      acq_cnt      <= '0;
      o_ctrl       <= 1'b0;
      o_sym_strobe <= 1'b0;
      o_en_taps    <= 1'b0;
      o_taps_I     <= TAPS_I_INIT;
      o_taps_Q     <= '0;
    end else begin
      state        <= state_nxt;
      fill_cnt     <= fill_cnt_nxt;
      acq_cnt      <= acq_cnt_nxt;
      o_ctrl       <= take_sample;
      o_sym_strobe <= sym_now;
      phase        <= phase ^ take_sample;
      o_en_taps    <= xfer;
      if (xfer) begin
        pending  <= 1'b1;
        o_taps_I <= taps_I_nxt;
        o_taps_Q <= taps_Q_nxt;
      end else if (o_sym_strobe) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fse_ctrl.md
Name: fse_ctrl

Overview:
Sequencing controller for the fractionally spaced equalizer (FSE) datapath. Generates the rate-2 shift strobe and the baud-rate tap-enable strobe for the FSE. Owns the packed I/Q tap bank and applies externally computed LMS tap deltas through a valid/ready handshake, at most one update per symbol. An IDLE -> FILL -> ACQ -> TRACK state machine selects the adaptation step size.

Parameters:
NUM_TAPS, 9, number of FSE taps per rail
NBT_TAPS, 10, tap total bits (signed)
NBF_TAPS, 7, tap fractional bits
ACQ_SYMBOLS, 1024, symbol strobes spent in ACQ before TRACK
ACQ_SHIFT, 2, arithmetic right shift applied to deltas in ACQ
TRK_SHIFT, 5, arithmetic right shift applied to deltas in TRACK

Ports:
clk  in  1  system clock
i_reset  in  1  synchronous reset, active-low
i_en_rx  in  1  receiver enable; low forces IDLE
i_valid  in  1  one FSE input sample (rate 2) present this cycle
i_freeze  in  1  hold taps; suppresses update acceptance
i_upd_valid  in  1  delta vectors valid
i_upd_dI  in  NUM_TAPS*NBT_TAPS  packed signed I-rail deltas, tap j at bits [(j+1)*NBT_TAPS-1 : j*NBT_TAPS]
i_upd_dQ  in  NUM_TAPS*NBT_TAPS  packed signed Q-rail deltas, same packing
o_upd_ready  out  1  controller accepts a delta vector this cycle
o_ctrl  out  1  FSE shift strobe
o_sym_strobe  out  1  baud-rate decision strobe
o_en_taps  out  1  FSE tap-load strobe
o_taps_I  out  NUM_TAPS*NBT_TAPS  packed I taps
o_taps_Q  out  NUM_TAPS*NBT_TAPS  packed Q taps
o_state  out  2  0=IDLE, 1=FILL, 2=ACQ, 3=TRACK

Behaviour:
- All state is registered on the rising edge of clk. Reset is synchronous: i_reset==0 is sampled at the edge.
- Reset values, also applied on every cycle i_en_rx==0:
  - state = IDLE; phase = 0; counters = 0.
  - o_ctrl, o_sym_strobe, o_en_taps, o_upd_ready = 0; pending = 0.
  - o_taps_Q = 0.
  - o_taps_I: tap NUM_TAPS/2 = 1<<NBF_TAPS (1.0, 128 at defaults); all other taps 0.
- Strobes, active only when state != IDLE:
  - o_ctrl = registered i_valid (1-cycle latency). Every accepted sample toggles phase.
  - o_sym_strobe pulses in the same cycle as o_ctrl whenever the accepted sample had phase==1 (every second sample).
- State machine:
  - IDLE -> FILL on the first cycle with i_reset==1 and i_en_rx==1.
  - FILL -> ACQ after NUM_TAPS accepted samples (shifter full). No updates are accepted in FILL.
  - ACQ -> TRACK on the ACQ_SYMBOLS-th o_sym_strobe counted in ACQ; the counter saturates.
  - TRACK holds until i_en_rx falls or reset.
  - Any state -> IDLE when i_en_rx==0, including mid-update: a pending update is discarded and taps are re-initialised.
- Update handshake:
  - o_upd_ready = (state in ACQ/TRACK) & !pending & !i_freeze.
  - Transfer occurs when i_upd_valid & o_upd_ready at cycle N. Deltas are captured, pending is set, and ready drops at N+1.
  - Cycle N+1: tap_j <= sat(tap_j + (delta_j >>> SHIFT)), with SHIFT = ACQ_SHIFT or TRK_SHIFT chosen by the state at cycle N. o_en_taps pulses high for exactly one cycle at N+1 with the new taps valid on o_taps_*.
  - pending clears on the next o_sym_strobe, giving at most one update per symbol. If the strobe lands in cycle N+1, pending still clears and ready rises at N+2.
  - i_upd_valid while ready is low is ignored; the requester must hold it.
- Arithmetic:
  - Shift is an arithmetic right shift (floor toward -inf).
  - Add is computed at NBT_TAPS+1 bits, then saturated to [-2^(NBT_TAPS-1), 2^(NBT_TAPS-1)-1], i.e. [-512, 511] at defaults.
  - The I and Q rails are updated independently.
- i_freeze:
  - Asserted after an accept, it does not cancel the in-flight update.
  - While high, ready stays 0 and the state counters still advance.
- Simultaneous events: i_reset==0 wins over i_en_rx; i_en_rx==0 wins over valid/update.

Test Plan:
1. Reset low 3 cycles, then en_rx=1 -> o_state 0 then 1; o_taps_I tap4=128, all others 0; o_taps_Q all 0; o_en_taps=0.
2. Continuous i_valid, 9 samples -> o_ctrl each cycle with 1-cycle lag; o_sym_strobe on every 2nd sample; o_state=2 after the 9th accepted sample; o_upd_ready=0 during FILL.
3. ACQ, dI tap4=+64 -> taps_I[4]=128+16=144, o_en_taps single pulse at N+1, ready low until the next sym_strobe. In TRACK, same delta -> +2.
4. taps_I[0]=500, delta +200 in ACQ -> 511; taps_I[0]=-510, delta -100 -> -512 (ACQ shift gives -25, sum -535 -> saturates); delta -1 in TRACK -> shift yields -1.
5. ACQ_SYMBOLS set to 4 -> o_state changes to 3 on the 4th sym_strobe in ACQ; updates after that use shift 5.
6. en_rx dropped at cycle N+1 of an update, or i_reset=0 mid-TRACK -> next cycle o_state=0, taps back to center-spike, o_en_taps=0, ready=0.
